// File: rtl/dmux8way16_bank.sv
// rtl/dmux8way16_bank.sv - registered 8-way 16-bit write bank with per-lane occupancy
module dmux8way16_bank (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  sel,
    input  logic        auto,
    input  logic [7:0]  clr,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic [15:0] c,
    output logic [15:0] d,
    output logic [15:0] e,
    output logic [15:0] f,
    output logic [15:0] g,
    output logic [15:0] h,
    output logic [7:0]  full,
    output logic [2:0]  ptr,
    output logic [3:0]  count
);

    logic [15:0] lane [8];
    logic [2:0]  tgt;
    logic        fire;
    logic [7:0]  full_next;
    logic [3:0]  pop_next;

    assign tgt      = auto ? ptr : sel;
    // No clear bypass: a lane freed by clr only becomes writable next cycle.
    assign in_ready = !full[tgt];
    assign fire     = in_valid && in_ready;

    always_comb begin
        full_next = full & ~clr;
        if (fire) begin
            full_next[tgt] = 1'b1;
        end
        pop_next = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop_next = pop_next + {3'b000, full_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                lane[i] <= 16'h0000;
            end
            full  <= 8'h00;
            ptr   <= 3'd0;
            count <= 4'd0;
        end else begin
            full  <= full_next;
            count <= pop_next;
            if (fire) begin
                lane[tgt] <= in;
                if (auto) begin
                    ptr <= ptr + 3'd1;
                end
            end
        end
    end

    assign a = lane[0];
    assign b = lane[1];
    assign c = lane[2];
    assign d = lane[3];
    assign e = lane[4];
    assign f = lane[5];
    assign g = lane[6];
    assign h = lane[7];

endmodule

// File: tb/tb_dmux8way16_bank.sv
// tb/tb_dmux8way16_bank.sv - randomized self-checking bench for dmux8way16_bank
module tb_dmux8way16_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic        auto_s;
    logic [7:0]  clr;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  full;
    logic [2:0]  ptr;
    logic [3:0]  count;

    wire [15:0] dl [8];
    assign dl[0] = a; assign dl[1] = b; assign dl[2] = c; assign dl[3] = d;
    assign dl[4] = e; assign dl[5] = f; assign dl[6] = g; assign dl[7] = h;

    int checks = 0;
    int errors = 0;

    // behavioural model: eight single-entry buffers and a wrapping pointer
    logic [15:0] mlane [8];
    bit          mfull [8];
    int          mptr;

    dmux8way16_bank dut (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .auto(auto_s), .clr(clr),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .full(full), .ptr(ptr), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mfull_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = mfull[i];
        return v;
    endfunction

    function automatic int mcount();
        int n = 0;
        for (int i = 0; i < 8; i++) if (mfull[i]) n++;
        return n;
    endfunction

    function automatic logic exp_ready();
        int t = auto_s ? mptr : int'(sel);
        return !mfull[t];
    endfunction

    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mlane[i] = 16'h0000;
                mfull[i] = 0;
            end
            mptr = 0;
        end else begin
            int  t   = auto_s ? mptr : int'(sel);
            bit  rdy = !mfull[t];
            for (int i = 0; i < 8; i++) if (clr[i]) mfull[i] = 0;
            if (in_valid && rdy) begin
                mlane[t] = din;
                mfull[t] = 1;
                if (auto_s) mptr = (mptr + 1) % 8;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; in_valid = 0; din = 16'h0000; sel = 3'd0; auto_s = 0; clr = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dl[i] !== 16'h0000) begin
                errors++; $display("FAIL reset_lane%0d got %h want 0000", i, dl[i]);
            end
        end
        checks++;
        if (full !== 8'h00) begin errors++; $display("FAIL reset_full got %h want 00", full); end
        checks++;
        if (ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", ptr); end
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_explicit();
        logic [15:0] words [8];
        words[0] = 16'h1234; words[1] = 16'h2345; words[2] = 16'h3456; words[3] = 16'h4567;
        words[4] = 16'h5678; words[5] = 16'h6789; words[6] = 16'h789A; words[7] = 16'h89AB;
        idle();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; din = words[i]; sel = 3'(i); auto_s = 0;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL explicit_ready%0d got %b want 1", i, in_ready); end
            tick();
            checks++;
            if (dl[i] !== words[i]) begin
                errors++; $display("FAIL explicit_lane%0d got %h want %h", i, dl[i], words[i]);
            end
        end
        idle();
        #1;
        checks++;
        if (full !== 8'hFF) begin errors++; $display("FAIL explicit_full got %h want FF", full); end
        checks++;
        if (count !== 4'd8) begin errors++; $display("FAIL explicit_count got %0d want 8", count); end
        checks++;
        if (ptr !== 3'd0) begin errors++; $display("FAIL explicit_ptr got %0d want 0", ptr); end
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (dl[s] !== mlane[s]) begin errors++; $display("FAIL explicit_mux%0d got %h want %h", s, dl[s], mlane[s]); end
        end
        clr = 8'hFF;
        tick();
        idle();
    endtask

    task automatic test_auto();
        logic [15:0] words [9];
        for (int i = 0; i < 9; i++) words[i] = 16'($urandom);
        idle();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; auto_s = 1; din = words[i]; sel = 3'($urandom);
            tick();
            checks++;
            if (ptr !== 3'((i + 1) % 8)) begin errors++; $display("FAIL auto_ptr%0d got %0d want %0d", i, ptr, (i + 1) % 8); end
            checks++;
            if (dl[i] !== words[i]) begin errors++; $display("FAIL auto_lane%0d got %h want %h", i, dl[i], words[i]); end
        end
        din = words[8];
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL auto_stall_ready got %b want 0", in_ready); end
        tick();
        checks++;
        if (ptr !== 3'd0 || full !== 8'hFF || a !== words[0]) begin
            errors++; $display("FAIL auto_stall_hold got ptr=%0d full=%h a=%h want ptr=0 full=FF a=%h", ptr, full, a, words[0]);
        end
        in_valid = 0; clr = 8'h01;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL auto_no_bypass got %b want 0", in_ready); end
        tick();
        clr = 8'h00;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL auto_clr_ready got %b want 1", in_ready); end
        in_valid = 1;
        tick();
        checks++;
        if (a !== words[8] || ptr !== 3'd1 || b !== words[1]) begin
            errors++; $display("FAIL auto_ninth got a=%h ptr=%0d b=%h want a=%h ptr=1 b=%h", a, ptr, b, words[8], words[1]);
        end
        idle();
        clr = 8'hFF;
        tick();
        idle();
    endtask

    task automatic test_collision();
        logic [15:0] w0 = 16'hD00D;
        logic [15:0] w1 = 16'hBEEF;
        idle();
        in_valid = 1; sel = 3'd3; din = w0;
        tick();
        din = w1; clr = 8'h08;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL collide_ready got %b want 0", in_ready); end
        tick();
        checks++;
        if (full[3] !== 1'b0 || d !== w0) begin
            errors++; $display("FAIL collide_edge got full3=%b d=%h want full3=0 d=%h", full[3], d, w0);
        end
        clr = 8'h00;
        tick();
        checks++;
        if (full[3] !== 1'b1 || d !== w1) begin
            errors++; $display("FAIL collide_retry got full3=%b d=%h want full3=1 d=%h", full[3], d, w1);
        end
        idle();
        clr = 8'hFF;
        tick();
        idle();
    endtask

    task automatic test_concurrent();
        idle();
        in_valid = 1; sel = 3'd0; din = 16'h0A0A; tick();
        sel = 3'd1; din = 16'h1B1B; tick();
        sel = 3'd2; din = 16'h2C2C; tick();
        sel = 3'd5; din = 16'h5E5E; clr = 8'h03;
        tick();
        checks++;
        if (full !== 8'h24) begin errors++; $display("FAIL concur_full got %h want 24", full); end
        checks++;
        if (count !== 4'd2) begin errors++; $display("FAIL concur_count got %0d want 2", count); end
        checks++;
        if (a !== 16'h0A0A || f !== 16'h5E5E) begin
            errors++; $display("FAIL concur_data got a=%h f=%h want a=0A0A f=5E5E", a, f);
        end
        idle();
        clr = 8'hFF;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 63) == 0);
            in_valid = 1'($urandom);
            auto_s   = 1'($urandom);
            sel      = 3'($urandom);
            din      = 16'($urandom);
            clr      = 8'($urandom & $urandom & $urandom);
            #1;
            checks++;
            if (in_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready@%0d got %b want %b", n, in_ready, exp_ready());
            end
            tick();
            checks++;
            if (full !== mfull_vec() || ptr !== 3'(mptr) || count !== 4'(mcount())) begin
                errors++;
                $display("FAIL rand_state@%0d got full=%h ptr=%0d count=%0d want full=%h ptr=%0d count=%0d",
                         n, full, ptr, count, mfull_vec(), mptr, mcount());
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (dl[i] !== mlane[i]) begin
                    errors++; $display("FAIL rand_lane%0d@%0d got %h want %h", i, n, dl[i], mlane[i]);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        reset = 1; tick(); reset = 0;
        in_valid = 1; auto_s = 1;
        for (int i = 0; i < 5; i++) begin
            din = 16'($urandom | 1); tick();
        end
        auto_s = 0; sel = 3'd5; din = 16'hCAFE; tick();
        in_valid = 0; clr = 8'h03; tick();
        clr = 8'h00;
        #1;
        checks++;
        if (full !== 8'h3C || ptr !== 3'd5) begin
            errors++; $display("FAIL midreset_setup got full=%h ptr=%0d want full=3C ptr=5", full, ptr);
        end
        reset = 1; in_valid = 1; auto_s = 1; din = 16'hFFFF; clr = 8'h10;
        tick();
        idle();
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dl[i] !== 16'h0000) begin errors++; $display("FAIL midreset_lane%0d got %h want 0000", i, dl[i]); end
        end
        checks++;
        if (full !== 8'h00 || ptr !== 3'd0 || count !== 4'd0) begin
            errors++; $display("FAIL midreset_state got full=%h ptr=%0d count=%0d want 00/0/0", full, ptr, count);
        end
    endtask

    initial begin
        test_reset();
        test_explicit();
        test_auto();
        test_collision();
        test_concurrent();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
